// File: rtl/cga_comp_pkg.sv
// Shared definitions for the CGA composite decode path.
// Grey levels are indexed by RGB (0..7); intensified colours sit INTENS_OFS
// above their base level; a colour cycle swings COLOUR_OFS above its trough.
package cga_comp_pkg;

  localparam logic [6:0] LVL_SYNC         = 7'd0;
  localparam logic [6:0] LVL_BURST_TROUGH = 7'd29;
  localparam logic [6:0] INTENS_OFS       = 7'd31;
  localparam logic [6:0] COLOUR_OFS       = 7'd28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_BURST  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  function automatic logic [6:0] grey_lvl(input logic [2:0] rgb);
    case (rgb)
      3'd0:    return 7'd29;
      3'd1:    return 7'd36;
      3'd2:    return 7'd49;
      3'd3:    return 7'd56;
      3'd4:    return 7'd39;
      3'd5:    return 7'd46;
      3'd6:    return 7'd60;
      default: return 7'd68;
    endcase
  endfunction

endpackage

// File: rtl/cga_comp_level_decode.sv
// Combinational decode of one colour-cycle window from its (min, max) levels.
//   lvl_min, lvl_max : smallest / largest composite level seen in the window
//   irgb             : decoded I,R,G,B (0 when unrecognised)
//   err              : no IRGB code produces this (min, max) pair
module cga_comp_level_decode
  import cga_comp_pkg::*;
(
  input  logic [6:0] lvl_min,
  input  logic [6:0] lvl_max,
  output logic [3:0] irgb,
  output logic       err
);

  always_comb begin
    irgb = 4'd0;
    err  = 1'b1;
    if (lvl_min == lvl_max) begin
      // Black and white carry no chroma, so the window is flat.
      if (lvl_min == grey_lvl(3'd0)) begin
        irgb = 4'b0000;
        err  = 1'b0;
      end else if (lvl_min == grey_lvl(3'd0) + INTENS_OFS) begin
        irgb = 4'b1000;
        err  = 1'b0;
      end else if (lvl_min == grey_lvl(3'd7) + COLOUR_OFS) begin
        irgb = 4'b0111;
        err  = 1'b0;
      end else if (lvl_min == grey_lvl(3'd7) + COLOUR_OFS + INTENS_OFS) begin
        irgb = 4'b1111;
        err  = 1'b0;
      end
    end else if ({1'b0, lvl_max} == {1'b0, lvl_min} + {1'b0, COLOUR_OFS}) begin
      // Widened compare so a trough near full scale cannot wrap onto a match.
      for (int i = 1; i <= 6; i++) begin
        if (lvl_min == grey_lvl(3'(i))) begin
          irgb = {1'b0, 3'(i)};
          err  = 1'b0;
        end else if (lvl_min == grey_lvl(3'(i)) + INTENS_OFS) begin
          irgb = {1'b1, 3'(i)};
          err  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cga_composite_decoder.sv
// CGA composite decoder: recovers hsync, vsync, burst phase and per-cycle IRGB
// from the 7-bit composite level stream. All state advances on sample_en.
//   clk, reset_n         : clock, asynchronous active-low reset
//   sample_en, comp_in   : sample strobe and composite level (0 = sync tip)
//   hsync, vsync         : separated sync
//   burst_lock, phase    : burst found on this line, sample index mod 4 of peak
//   pix_valid, pix_irgb  : one-clk pulse per decoded 4-sample window
//   decode_err           : pulses with pix_valid when the window is unrecognised
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, waiting for the first accepted sync run
// ST_SYNC   | in sync tip, burst_lock cleared
// ST_BURST  | searching for 29 -> BURST_LVL within BURST_WIN samples
// ST_ACTIVE | decoding 4-sample windows aligned to phase (if locked)
module cga_composite_decoder
  import cga_comp_pkg::*;
#(
  parameter int HSYNC_MIN = 3,
  parameter int VSYNC_MIN = 64,
  parameter int BURST_WIN = 48,
  parameter int BURST_LVL = 57
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_en,
  input  logic [6:0] comp_in,
  output logic       hsync,
  output logic       vsync,
  output logic       burst_lock,
  output logic [1:0] phase,
  output logic       pix_valid,
  output logic [3:0] pix_irgb,
  output logic       decode_err
);

  localparam logic [7:0] HS_MIN = 8'(HSYNC_MIN);
  localparam logic [7:0] VS_MIN = 8'(VSYNC_MIN);

  state_t     state;
  logic [7:0] run_cnt;
  logic [1:0] samp_cnt;
  logic [6:0] prev_lvl;
  logic [7:0] win_cnt;
  logic       win_act;
  logic [6:0] win_min;
  logic [6:0] win_max;

  logic       is_sync;
  logic [7:0] run_next;
  logic [1:0] win_pos;
  logic [6:0] upd_min;
  logic [6:0] upd_max;
  logic [3:0] dec_irgb;
  logic       dec_err;

  always_comb begin
    is_sync  = (comp_in == LVL_SYNC);
    run_next = 8'd0;
    if (is_sync) run_next = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
    win_pos  = samp_cnt - phase;
    // Slot 0 restarts the window; later slots fold into the running extremes.
    upd_min  = comp_in;
    upd_max  = comp_in;
    if (win_pos != 2'd0) begin
      upd_min = (comp_in < win_min) ? comp_in : win_min;
      upd_max = (comp_in > win_max) ? comp_in : win_max;
    end
  end

  cga_comp_level_decode u_level_decode (
    .lvl_min (upd_min),
    .lvl_max (upd_max),
    .irgb    (dec_irgb),
    .err     (dec_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      run_cnt    <= 8'd0;
      samp_cnt   <= 2'd0;
      prev_lvl   <= 7'd0;
      win_cnt    <= 8'd0;
      win_act    <= 1'b0;
      win_min    <= 7'd0;
      win_max    <= 7'd0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      burst_lock <= 1'b0;
      phase      <= 2'd0;
      pix_valid  <= 1'b0;
      pix_irgb   <= 4'd0;
      decode_err <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      decode_err <= 1'b0;
      if (sample_en) begin
        run_cnt  <= run_next;
        samp_cnt <= samp_cnt + 2'd1;
        prev_lvl <= comp_in;

        hsync <= is_sync && (run_next >= HS_MIN) && (run_next < VS_MIN);
        // vsync survives the end of the long run; only a later short
        // accepted sync, judged at its rising edge, clears it.
        if (is_sync && (run_next >= VS_MIN))
          vsync <= 1'b1;
        else if (!is_sync && (run_cnt >= HS_MIN) && (run_cnt < VS_MIN))
          vsync <= 1'b0;

        case (state)
          ST_IDLE: begin
            if (run_next >= HS_MIN) begin
              state      <= ST_SYNC;
              burst_lock <= 1'b0;
            end
          end
          ST_SYNC: begin
            if (!is_sync) begin
              state   <= ST_BURST;
              win_cnt <= 8'(BURST_WIN - 1);
            end
          end
          ST_BURST: begin
            if ((comp_in == 7'(BURST_LVL)) && (prev_lvl == LVL_BURST_TROUGH)) begin
              phase      <= samp_cnt;
              burst_lock <= 1'b1;
              win_act    <= 1'b0;
              state      <= ST_ACTIVE;
            end else if (win_cnt == 8'd1) begin
              burst_lock <= 1'b0;
              win_act    <= 1'b0;
              state      <= ST_ACTIVE;
            end else begin
              win_cnt <= win_cnt - 8'd1;
            end
          end
          ST_ACTIVE: begin
            if (is_sync) begin
              state      <= ST_SYNC;
              burst_lock <= 1'b0;
              win_act    <= 1'b0;
            end else if (burst_lock && ((win_pos == 2'd0) || win_act)) begin
              win_min <= upd_min;
              win_max <= upd_max;
              if (win_pos == 2'd3) begin
                win_act    <= 1'b0;
                pix_valid  <= 1'b1;
                pix_irgb   <= dec_irgb;
                decode_err <= dec_err;
              end else begin
                win_act <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cga_composite_decoder.sv
// Bench for cga_composite_decoder: builds composite lines from sync, burst
// and encoder-shaped colour windows, queues the expected pixel per window,
// and a monitor pops the queue on every pix_valid.
module tb_cga_composite_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sample_en = 1'b0;
  logic [6:0] comp_in = 7'd0;
  logic       hsync, vsync, burst_lock, pix_valid, decode_err;
  logic [1:0] phase;
  logic [3:0] pix_irgb;

  cga_composite_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .comp_in    (comp_in),
    .hsync      (hsync),
    .vsync      (vsync),
    .burst_lock (burst_lock),
    .phase      (phase),
    .pix_valid  (pix_valid),
    .pix_irgb   (pix_irgb),
    .decode_err (decode_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];          // bit 4 = decode_err, bits 3:0 = irgb
  int tbl_min[16];
  int tbl_max[16];
  int run_len = 0;
  bit exp_vs = 1'b0;
  int sidx = 0;          // index of the next sample since reset
  int last_phase = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: look the pair up in the table of legal code levels.
  function automatic int ref_decode(input int mn, input int mx);
    for (int c = 0; c < 16; c++)
      if (tbl_min[c] == mn && tbl_max[c] == mx) return c;
    return 16;
  endfunction

  task automatic send(input int lvl);
    int prev_run;
    prev_run = run_len;
    comp_in = 7'(lvl);
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    sidx++;
    run_len = (lvl == 0) ? run_len + 1 : 0;
    if (lvl == 0 && run_len >= 64) exp_vs = 1'b1;
    else if (lvl != 0 && prev_run >= 3 && prev_run < 64) exp_vs = 1'b0;
    chk("hsync", int'(hsync), int'(lvl == 0 && run_len >= 3 && run_len < 64));
    chk("vsync", int'(vsync), int'(exp_vs));
    @(posedge clk); #1;
  endtask

  task automatic send_win(input int a, input int b, input int c, input int d);
    int mn, mx;
    mn = a; mx = a;
    if (b < mn) mn = b; if (b > mx) mx = b;
    if (c < mn) mn = c; if (c > mx) mx = c;
    if (d < mn) mn = d; if (d > mx) mx = d;
    send(a); send(b); send(c);
    exp_q.push_back(ref_decode(mn, mx));
    send(d);
  endtask

  // Encoder-shaped window: each slot at trough or peak, both present.
  task automatic code_win(input int code);
    int v[4];
    int j, r;
    for (int k = 0; k < 4; k++)
      v[k] = ($urandom_range(0, 1) == 1) ? tbl_max[code] : tbl_min[code];
    j = int'($urandom_range(0, 3));
    r = int'($urandom_range(1, 3));
    v[j] = tbl_min[code];
    v[(j + r) % 4] = tbl_max[code];
    send_win(v[0], v[1], v[2], v[3]);
  endtask

  task automatic rand_win();
    if ($urandom_range(0, 9) < 7) code_win(int'($urandom_range(0, 15)));
    else send_win(int'($urandom_range(1, 127)), int'($urandom_range(1, 127)),
                  int'($urandom_range(1, 127)), int'($urandom_range(1, 127)));
  endtask

  task automatic do_sync(input int len);
    repeat (len) send(0);
    chk("lock_clear_in_sync", int'(burst_lock), 0);
  endtask

  // Sync, then 29s so the first 57 lands on sample index ph (mod 4), then
  // the rest of the burst cycle so the first window starts on the next ph.
  task automatic lock_preamble(input int sync_len, input int ph);
    int k;
    do_sync(sync_len);
    k = 10;
    while (((sidx + k) % 4) != ph) k++;
    repeat (k) send(29);
    send(57);
    chk("burst_lock", int'(burst_lock), 1);
    chk("phase", int'(phase), ph);
    last_phase = ph;
    send(57); send(29); send(29);
  endtask

  task automatic unlocked_line(input int sync_len);
    do_sync(sync_len);
    repeat (60) send(29);
    chk("burst_lock_expired", int'(burst_lock), 0);
    chk("phase_held", int'(phase), last_phase);
    repeat (8) send(int'($urandom_range(1, 127)));
  endtask

  task automatic chk_outs_zero(input string name);
    chk({name, "_hsync"}, int'(hsync), 0);
    chk({name, "_vsync"}, int'(vsync), 0);
    chk({name, "_lock"}, int'(burst_lock), 0);
    chk({name, "_phase"}, int'(phase), 0);
    chk({name, "_valid"}, int'(pix_valid), 0);
    chk({name, "_irgb"}, int'(pix_irgb), 0);
    chk({name, "_err"}, int'(decode_err), 0);
  endtask

  always @(negedge clk) begin
    if (pix_valid) begin
      if (exp_q.size() == 0) begin
        chk("pix_unexpected", int'(pix_valid), 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("pix_irgb", int'(pix_irgb), e & 15);
        chk("decode_err", int'(decode_err), e >> 4);
      end
    end
    if (decode_err && !pix_valid) chk("err_without_valid", int'(decode_err), 0);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grey[8];
    grey = '{29, 36, 49, 56, 39, 46, 60, 68};
    for (int c = 0; c < 16; c++) begin
      int ibit, rgb;
      ibit = (c >> 3) & 1;
      rgb  = c & 7;
      if (rgb == 0 || rgb == 7) begin
        tbl_min[c] = ((rgb == 7) ? 96 : 29) + 31 * ibit;
        tbl_max[c] = tbl_min[c];
      end else begin
        tbl_min[c] = grey[rgb] + 31 * ibit;
        tbl_max[c] = tbl_min[c] + 28;
      end
    end

    #2 reset_n = 1'b0;
    #1 chk_outs_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Short sync, lock at phase 2, directed windows.
    lock_preamble(8, 2);
    send_win(36, 36, 64, 64);
    send_win(29, 29, 29, 29);
    send_win(60, 60, 60, 60);
    send_win(29, 29, 29, 29);
    send_win(40, 40, 40, 40);

    // Full sweep of all 16 codes.
    lock_preamble(5, 1);
    for (int c = 0; c < 16; c++) code_win(c);

    // Long sync raises vsync; next short sync clears it at its end.
    lock_preamble(200, 3);
    repeat (6) rand_win();
    lock_preamble(3, 0);
    repeat (6) rand_win();

    // Sync sample in the 3rd slot aborts the window.
    lock_preamble(10, 1);
    code_win(3);
    send(36); send(64); send(0);
    repeat (60) send(29);
    chk("lock_after_abort", int'(burst_lock), 0);

    unlocked_line(12);

    lock_preamble(63, 2);
    repeat (4) rand_win();
    lock_preamble(64, 0);
    repeat (4) rand_win();

    for (int l = 0; l < 6; l++) begin
      int nw;
      lock_preamble(int'($urandom_range(3, 40)), int'($urandom_range(0, 3)));
      nw = int'($urandom_range(2, 8));
      repeat (nw) rand_win();
    end

    // Reset in the middle of a window, then no pixels until a new lock.
    lock_preamble(8, 1);
    code_win(5);
    send(36); send(36);
    reset_n = 1'b0;
    #1 chk_outs_zero("midreset");
    @(posedge clk); #1;
    chk_outs_zero("midreset_clk");
    reset_n = 1'b1;
    sidx = 0; run_len = 0; exp_vs = 1'b0; last_phase = 0;
    @(posedge clk); #1;
    send(0); send(0); send(29); send(57);
    repeat (30) send(int'($urandom_range(1, 127)));
    chk("no_lock_after_reset", int'(burst_lock), 0);
    lock_preamble(8, 3);
    repeat (5) rand_win();

    repeat (10) @(posedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
